// File: rtl/watch_pkg.sv
// Shared types and constants for the watch setting controller.
//   state_t : controller state, also driven out as the mode code
//   time_t  : hour/min/sec edit payload
package watch_pkg;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MS_W   = 6;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MS_W-1:0]   MIN_MAX  = 6'd59;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MS_W-1:0]   min;
        logic [MS_W-1:0]   sec;
    } time_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler counting 0..TICK_DIV-1.
//   clk, rst : clock, async active-low reset
//   clr      : synchronous clear to 0 (takes priority over counting)
//   cnt      : prescaler value (registered)
//   tick     : decode of cnt == TICK_DIV-1 (combinational)
module tick_gen #(
    parameter  int unsigned TICK_DIV = 50000000,
    localparam int unsigned CNT_W    = $clog2(TICK_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             tick
);

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    // Prescaler register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/watch_ctrl.sv
// Watch sequencing and time-setting controller.
//   clk, rst          : clock, async active-low reset
//   btn_mode, btn_inc : single-cycle button pulses (debounced)
//   cur_hour/min/sec  : live watch time, captured on entry to set mode
//   ci                : one-cycle seconds tick to the watch (RUN only)
//   ld                : one-cycle load strobe on commit
//   hour/min/sec_set  : edit registers, valid with ld
//   mode              : state code (0 RUN, 1 SET_H, 2 SET_M, 3 SET_S)
//   blink             : blink enable for the field being edited
module watch_ctrl
    import watch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MS_W-1:0]   cur_min,
    input  logic [MS_W-1:0]   cur_sec,
    output logic              ci,
    output logic              ld,
    output logic [HOUR_W-1:0] hour_set,
    output logic [MS_W-1:0]   min_set,
    output logic [MS_W-1:0]   sec_set,
    output logic [1:0]        mode,
    output logic              blink
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);

    state_t           state, state_nx;
    time_t            edit, edit_nx;
    logic             ci_nx, ld_nx, blink_nx;
    logic             clr;
    logic [CNT_W-1:0] cnt;
    logic             tick;

    // Commit restarts the prescaler so the first second after ld is a full one
    assign clr = (state == SET_S) && btn_mode;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .cnt  (cnt),
        .tick (tick)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            edit  <= '0;
            ci    <= 1'b0;
            ld    <= 1'b0;
            blink <= 1'b0;
        end else begin
            state <= state_nx;
            edit  <= edit_nx;
            ci    <= ci_nx;
            ld    <= ld_nx;
            blink <= blink_nx;
        end
    end

    // Next state, edit registers and strobes; btn_mode has priority over btn_inc
    always_comb begin
        state_nx = state;
        edit_nx  = edit;
        ld_nx    = 1'b0;
        ci_nx    = tick && (state == RUN);
        blink_nx = (state != RUN) && (cnt < CNT_W'(TICK_DIV / 2));

        if (btn_mode) begin
            unique case (state)
                RUN: begin
                    state_nx     = SET_H;
                    edit_nx.hour = cur_hour;
                    edit_nx.min  = cur_min;
                    edit_nx.sec  = cur_sec;
                end
                SET_H: state_nx = SET_M;
                SET_M: state_nx = SET_S;
                SET_S: begin
                    state_nx = RUN;
                    ld_nx    = 1'b1;
                end
            endcase
        end else if (btn_inc) begin
            // >= so out-of-range captured values also wrap to 0
            unique case (state)
                RUN: ;
                SET_H: edit_nx.hour = (edit.hour >= HOUR_MAX) ? '0 : edit.hour + HOUR_W'(1);
                SET_M: edit_nx.min  = (edit.min  >= MIN_MAX)  ? '0 : edit.min  + MS_W'(1);
                SET_S: edit_nx.sec  = (edit.sec  >= MIN_MAX)  ? '0 : edit.sec  + MS_W'(1);
            endcase
        end
    end

    assign hour_set = edit.hour;
    assign min_set  = edit.min;
    assign sec_set  = edit.sec;
    assign mode     = state;

endmodule

// File: tb/tb_watch_ctrl.sv
// Self-checking bench for watch_ctrl with TICK_DIV = 4.
module tb_watch_ctrl;
    import watch_pkg::*;

    localparam int unsigned TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] cur_hour = '0;
    logic [5:0] cur_min = '0;
    logic [5:0] cur_sec = '0;
    logic       ci, ld, blink;
    logic [4:0] hour_set;
    logic [5:0] min_set, sec_set;
    logic [1:0] mode;

    int    tests_run = 0;
    int    fails = 0;
    int    cnt_m = 0;
    time_t exp_q[$];

    always #5 clk = ~clk;

    watch_ctrl #(.TICK_DIV(TD)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .cur_hour (cur_hour),
        .cur_min  (cur_min),
        .cur_sec  (cur_sec),
        .ci       (ci),
        .ld       (ld),
        .hour_set (hour_set),
        .min_set  (min_set),
        .sec_set  (sec_set),
        .mode     (mode),
        .blink    (blink)
    );

    // Drive buttons for one edge, land 1 time unit after it, track prescaler
    task automatic step(input logic m, input logic i, input logic clr);
        btn_mode = m;
        btn_inc  = i;
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cnt_m = clr ? 0 : (cnt_m + 1) % TD;
    endtask

    task automatic test_reset();
        logic exp_ci;
        rst = 1'b0;
        #12;
        tests_run++;
        if ({ci, ld, blink, mode, hour_set, min_set, sec_set} !== '0) begin
            fails++;
            $display("FAIL reset_values: ci=%b ld=%b blink=%b mode=%0d set=%0d:%0d:%0d, want all 0",
                     ci, ld, blink, mode, hour_set, min_set, sec_set);
        end
        @(negedge clk);
        rst   = 1'b1;
        cnt_m = 0;
        for (int k = 1; k <= 12; k++) begin
            exp_ci = (cnt_m == TD - 1);
            step(1'b0, 1'b0, 1'b0);
            tests_run++;
            if (ci !== exp_ci) begin
                fails++;
                $display("FAIL run_ci edge %0d: got %b want %b", k, ci, exp_ci);
            end
            tests_run++;
            if ({ld, blink, mode} !== 4'b0) begin
                fails++;
                $display("FAIL run_idle edge %0d: ld=%b blink=%b mode=%0d, want 0", k, ld, blink, mode);
            end
        end
    endtask

    task automatic test_enter_set();
        logic exp_blink;
        cur_hour = 5'd12;
        cur_min  = 6'd34;
        cur_sec  = 6'd56;
        step(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (mode !== 2'd1) begin
            fails++;
            $display("FAIL enter_mode: got %0d want 1", mode);
        end
        tests_run++;
        if ({hour_set, min_set, sec_set} !== {5'd12, 6'd34, 6'd56}) begin
            fails++;
            $display("FAIL enter_capture: got %0d:%0d:%0d want 12:34:56", hour_set, min_set, sec_set);
        end
        for (int j = 1; j <= 20; j++) begin
            exp_blink = (cnt_m < TD / 2);
            step(1'b0, 1'b0, 1'b0);
            tests_run++;
            if (ci !== 1'b0) begin
                fails++;
                $display("FAIL set_ci cycle %0d: got %b want 0", j, ci);
            end
            tests_run++;
            if (blink !== exp_blink) begin
                fails++;
                $display("FAIL set_blink cycle %0d: got %b want %b", j, blink, exp_blink);
            end
        end
    endtask

    // Commit from SET_S and check ld, payload and tick restart
    task automatic commit_and_check(input time_t want);
        logic exp_ci;
        time_t got;
        exp_q.push_back(want);
        step(1'b1, 1'b0, 1'b1);
        tests_run++;
        if ({ld, ci, mode} !== {1'b1, 1'b0, 2'd0}) begin
            fails++;
            $display("FAIL commit_strobe: ld=%b ci=%b mode=%0d, want ld=1 ci=0 mode=0", ld, ci, mode);
        end
        if (ld === 1'b1 && exp_q.size() > 0) begin
            got  = {hour_set, min_set, sec_set};
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
                fails++;
                $display("FAIL commit_payload: got %0d:%0d:%0d want %0d:%0d:%0d",
                         got.hour, got.min, got.sec, want.hour, want.min, want.sec);
            end
        end
        for (int k = 1; k <= TD; k++) begin
            exp_ci = (k == TD);
            step(1'b0, 1'b0, 1'b0);
            tests_run++;
            if ({ld, ci} !== {1'b0, exp_ci}) begin
                fails++;
                $display("FAIL post_commit cycle %0d: ld=%b ci=%b, want ld=0 ci=%b", k, ld, ci, exp_ci);
            end
        end
    endtask

    task automatic test_inc_wrap();
        // SET_H at 12 on entry
        for (int k = 0; k < 11; k++) step(1'b0, 1'b1, 1'b0);
        tests_run++;
        if (hour_set !== 5'd23) begin
            fails++;
            $display("FAIL hour_reach_23: got %0d want 23", hour_set);
        end
        step(1'b0, 1'b1, 1'b0);
        tests_run++;
        if ({hour_set, min_set, sec_set} !== {5'd0, 6'd34, 6'd56}) begin
            fails++;
            $display("FAIL hour_wrap: got %0d:%0d:%0d want 0:34:56", hour_set, min_set, sec_set);
        end
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 25; k++) step(1'b0, 1'b1, 1'b0);
        tests_run++;
        if ({mode, min_set} !== {2'd2, 6'd59}) begin
            fails++;
            $display("FAIL min_reach_59: mode=%0d min=%0d want mode=2 min=59", mode, min_set);
        end
        step(1'b0, 1'b1, 1'b0);
        tests_run++;
        if ({hour_set, min_set, sec_set} !== {5'd0, 6'd0, 6'd56}) begin
            fails++;
            $display("FAIL min_wrap: got %0d:%0d:%0d want 0:0:56", hour_set, min_set, sec_set);
        end
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0);
        tests_run++;
        if ({mode, sec_set} !== {2'd3, 6'd0}) begin
            fails++;
            $display("FAIL sec_wrap: mode=%0d sec=%0d want mode=3 sec=0", mode, sec_set);
        end
        commit_and_check('{hour: 5'd0, min: 6'd0, sec: 6'd0});
    endtask

    task automatic test_sequence();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (mode !== 2'd3) begin
            fails++;
            $display("FAIL seq_mode: got %0d want 3", mode);
        end
        commit_and_check('{hour: 5'd14, min: 6'd34, sec: 6'd56});
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        tests_run++;
        if ({mode, hour_set} !== {2'd2, 5'd12}) begin
            fails++;
            $display("FAIL mode_beats_inc: mode=%0d hour=%0d want mode=2 hour=12", mode, hour_set);
        end
    endtask

    task automatic test_reset_mid_edit();
        logic exp_ci;
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({ci, ld, blink, mode, hour_set, min_set, sec_set} !== '0) begin
            fails++;
            $display("FAIL async_reset: ci=%b ld=%b blink=%b mode=%0d set=%0d:%0d:%0d, want all 0",
                     ci, ld, blink, mode, hour_set, min_set, sec_set);
        end
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
        cnt_m = 0;
        for (int k = 1; k <= 8; k++) begin
            exp_ci = (cnt_m == TD - 1);
            step(1'b0, 1'b0, 1'b0);
            tests_run++;
            if ({ci, ld, mode} !== {exp_ci, 1'b0, 2'd0}) begin
                fails++;
                $display("FAIL reset_resume edge %0d: ci=%b ld=%b mode=%0d, want ci=%b ld=0 mode=0",
                         k, ci, ld, mode, exp_ci);
            end
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d loads never seen, want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_enter_set();
        test_inc_wrap();
        test_sequence();
        test_back_to_back();
        test_reset_mid_edit();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
